// File: rtl/quad_color_ctrl_pkg.sv
// Shared definitions for the quadrant colour controller: FSM encoding,
// RGB888 width and the 3-bit colour code expansion.
package quad_color_ctrl_pkg;

  localparam int COLOR_W = 24;
  localparam logic [7:0] CH_ON  = 8'hFF;
  localparam logic [7:0] CH_OFF = 8'h00;

  typedef logic [COLOR_W-1:0] rgb_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    ROTATE = 2'd2
  } fsm_state_e;

  // {R,G,B} code bits each become a full-scale or dark 8-bit channel
  function automatic rgb_t expand_rgb(input logic [2:0] code);
    expand_rgb = {code[2] ? CH_ON : CH_OFF,
                  code[1] ? CH_ON : CH_OFF,
                  code[0] ? CH_ON : CH_OFF};
  endfunction

endpackage

// File: rtl/quad_color_ctrl_key_debounce.sv
// Active-low pushbutton conditioner: 2-flop synchronizer, stability
// counter and a single-cycle pulse on each accepted press.
module key_debounce #(
  parameter int DB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic press
);

  localparam int CW = $clog2(DB_CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  // cnt counts consecutive synchronized samples that disagree with level
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= key;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DB_CYCLES - 1)) begin
        cnt   <= '0;
        level <= sync2;
        press <= ~sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/quad_color_ctrl.sv
// Four-quadrant colour register bank: key-driven single-quadrant writes
// and periodic forward/backward rotation of all four colours.
module quad_color_ctrl
  import quad_color_ctrl_pkg::*;
#(
  parameter int DB_CYCLES  = 500000,
  parameter int ROT_CYCLES = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key3,
  input  logic [1:0] SW2,
  input  logic [2:0] SW3,
  input  logic       rot_en,
  input  logic       rot_dir,
  output rgb_t       color0,
  output rgb_t       color1,
  output rgb_t       color2,
  output rgb_t       color3,
  output logic       ledg,
  output fsm_state_e state_dbg
);

  localparam int RW = $clog2(ROT_CYCLES);

  fsm_state_e    state;
  logic          press;
  logic          press_pend;
  logic          rot_pend;
  logic [RW-1:0] rot_cnt;
  logic [1:0]    cap_idx;
  rgb_t          cap_col;
  rgb_t          color_q [4];

  key_debounce #(.DB_CYCLES(DB_CYCLES)) u_key (
    .clk   (clk),
    .rst   (rst),
    .key   (key3),
    .press (press)
  );

  // A wrap in the ROTATE cycle re-arms the pending flag for the next period
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rot_cnt  <= '0;
      rot_pend <= 1'b0;
    end else if (!rot_en) begin
      rot_cnt  <= '0;
      rot_pend <= 1'b0;
    end else begin
      if (state == ROTATE) rot_pend <= 1'b0;
      if (rot_cnt == RW'(ROT_CYCLES - 1)) begin
        rot_cnt  <= '0;
        rot_pend <= 1'b1;
      end else begin
        rot_cnt <= rot_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      press_pend <= 1'b0;
      cap_idx    <= '0;
      cap_col    <= '0;
      ledg       <= 1'b0;
      for (int i = 0; i < 4; i++) color_q[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (press || press_pend) begin
            cap_idx    <= SW2;
            cap_col    <= expand_rgb(SW3);
            press_pend <= press & press_pend;
            state      <= WRITE;
          end else if (rot_pend) begin
            state <= ROTATE;
          end
        end
        WRITE: begin
          color_q[cap_idx] <= cap_col;
          if (press) press_pend <= 1'b1;
          state <= IDLE;
        end
        ROTATE: begin
          if (!rot_dir) begin
            color_q[0] <= color_q[1];
            color_q[1] <= color_q[2];
            color_q[2] <= color_q[3];
            color_q[3] <= color_q[0];
          end else begin
            color_q[0] <= color_q[3];
            color_q[1] <= color_q[0];
            color_q[2] <= color_q[1];
            color_q[3] <= color_q[2];
          end
          ledg <= ~ledg;
          if (press) press_pend <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign color0    = color_q[0];
  assign color1    = color_q[1];
  assign color2    = color_q[2];
  assign color3    = color_q[3];
  assign state_dbg = state;

endmodule

// File: tb/tb_quad_color_ctrl.sv
// Bench for quad_color_ctrl: directed scenarios plus random key/rotation
// traffic, checked every cycle against an event-level reference model.
module tb_quad_color_ctrl;
  import quad_color_ctrl_pkg::*;

  localparam int DB  = 4;
  localparam int ROT = 10;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        key3;
  logic [1:0]  SW2;
  logic [2:0]  SW3;
  logic        rot_en;
  logic        rot_dir;
  logic [23:0] color0, color1, color2, color3;
  logic        ledg;
  fsm_state_e  state_dbg;

  quad_color_ctrl #(.DB_CYCLES(DB), .ROT_CYCLES(ROT)) dut (
    .clk       (clk),
    .rst       (rst),
    .key3      (key3),
    .SW2       (SW2),
    .SW3       (SW3),
    .rot_en    (rot_en),
    .rot_dir   (rot_dir),
    .color0    (color0),
    .color1    (color1),
    .color2    (color2),
    .color3    (color3),
    .ledg      (ledg),
    .state_dbg (state_dbg)
  );

  int n_tests;
  int n_fail;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [23:0] rgb_of(input logic [2:0] c);
    return {c[2] ? 8'hFF : 8'h00, c[1] ? 8'hFF : 8'h00, c[0] ? 8'hFF : 8'h00};
  endfunction

  // reference model: m_op is the job running this cycle (0 none, 1 write, 2 rotate)
  logic [23:0] m_col [4];
  logic        m_ledg;
  int          m_op;
  logic        m_press_pend;
  logic        m_rot_pend;
  logic        m_pulse;
  logic        m_level;
  int          m_run;
  logic [1:0]  m_cap_idx;
  logic [23:0] m_cap_col;
  logic        kh [$];

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) m_col[i] = '0;
    m_ledg       = 1'b0;
    m_op         = 0;
    m_press_pend = 1'b0;
    m_rot_pend   = 1'b0;
    m_pulse      = 1'b0;
    m_level      = 1'b1;
    m_run        = 0;
    m_cap_idx    = '0;
    m_cap_col    = '0;
    kh.delete();
    for (int i = 0; i < DB + 1; i++) kh.push_back(1'b1);
  endfunction

  function automatic void model_step();
    logic [23:0] c [4];
    int   nop;
    logic npp, nrp, npulse, all_eq, w0;
    c   = m_col;
    nop = 0;
    npp = m_press_pend;
    nrp = m_rot_pend;
    case (m_op)
      1: begin
        c[m_cap_idx] = m_cap_col;
        if (m_pulse) npp = 1'b1;
      end
      2: begin
        if (!rot_dir) c = '{m_col[1], m_col[2], m_col[3], m_col[0]};
        else          c = '{m_col[3], m_col[0], m_col[1], m_col[2]};
        m_ledg = ~m_ledg;
        nrp    = 1'b0;
        if (m_pulse) npp = 1'b1;
      end
      default: begin
        if (m_pulse || m_press_pend) begin
          m_cap_idx = SW2;
          m_cap_col = rgb_of(SW3);
          nop       = 1;
          npp       = m_pulse && m_press_pend;
        end else if (m_rot_pend) begin
          nop = 2;
        end
      end
    endcase
    // every ROT-th enabled cycle since enable marks a rotation due
    if (!rot_en) begin
      m_run = 0;
      nrp   = 1'b0;
    end else begin
      m_run++;
      if (m_run % ROT == 0) nrp = 1'b1;
    end
    // key level is accepted once DB samples (seen two cycles late) agree
    w0     = kh[0];
    all_eq = 1'b1;
    for (int i = 0; i < DB; i++) if (kh[i] != w0) all_eq = 1'b0;
    npulse = 1'b0;
    if (all_eq && (w0 != m_level)) begin
      m_level = w0;
      npulse  = !w0;
    end
    kh.push_back(key3);
    void'(kh.pop_front());
    m_col        = c;
    m_op         = nop;
    m_press_pend = npp;
    m_rot_pend   = nrp;
    m_pulse      = npulse;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) model_reset();
    else      model_step();
  end

  // scoreboard: compare every cycle, 1 time unit after the edge
  always @(posedge clk) begin
    fsm_state_e exp_st;
    #1;
    case (m_op)
      1:       exp_st = WRITE;
      2:       exp_st = ROTATE;
      default: exp_st = IDLE;
    endcase
    chk("cyc_color0", 32'(color0), 32'(m_col[0]));
    chk("cyc_color1", 32'(color1), 32'(m_col[1]));
    chk("cyc_color2", 32'(color2), 32'(m_col[2]));
    chk("cyc_color3", 32'(color3), 32'(m_col[3]));
    chk("cyc_ledg",   32'(ledg),   32'(m_ledg));
    chk("cyc_state",  32'(state_dbg), 32'(exp_st));
  end

  // driver tasks
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_press(input logic [1:0] idx, input logic [2:0] code);
    SW2  = idx;
    SW3  = code;
    key3 = 1'b0;
    cyc(10);
    key3 = 1'b1;
    cyc(10);
  endtask

  task automatic load_pattern();
    do_press(2'd0, 3'b001);
    do_press(2'd1, 3'b010);
    do_press(2'd2, 3'b100);
    do_press(2'd3, 3'b111);
  endtask

  task automatic chk_colors(input string tag, input logic [23:0] e0, input logic [23:0] e1,
                            input logic [23:0] e2, input logic [23:0] e3);
    chk({tag, "_c0"}, 32'(color0), 32'(e0));
    chk({tag, "_c1"}, 32'(color1), 32'(e1));
    chk({tag, "_c2"}, 32'(color2), 32'(e2));
    chk({tag, "_c3"}, 32'(color3), 32'(e3));
  endtask

  initial begin
    int key_left;
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b0;
    key3    = 1'b1;
    SW2     = '0;
    SW3     = '0;
    rot_en  = 1'b0;
    rot_dir = 1'b0;
    cyc(3);
    chk_colors("reset", 24'h0, 24'h0, 24'h0, 24'h0);
    chk("reset_ledg", 32'(ledg), 32'd0);
    rst = 1'b1;

    // long press writes quadrant 2 exactly once
    SW2 = 2'd2; SW3 = 3'b100; key3 = 1'b0;
    cyc(20);
    key3 = 1'b1;
    cyc(10);
    chk_colors("write", 24'h0, 24'h0, 24'hFF0000, 24'h0);

    // short glitch is filtered out
    SW2 = 2'd1; SW3 = 3'b111; key3 = 1'b0;
    cyc(2);
    key3 = 1'b1;
    cyc(12);
    chk_colors("glitch", 24'h0, 24'h0, 24'hFF0000, 24'h0);

    // forward rotation
    load_pattern();
    chk_colors("load", 24'h0000FF, 24'h00FF00, 24'hFF0000, 24'hFFFFFF);
    rot_dir = 1'b0; rot_en = 1'b1;
    cyc(13);
    rot_en = 1'b0;
    cyc(2);
    chk_colors("rot_fwd", 24'h00FF00, 24'hFF0000, 24'hFFFFFF, 24'h0000FF);
    chk("rot_fwd_ledg", 32'(ledg), 32'd1);

    // backward rotation
    load_pattern();
    rot_dir = 1'b1; rot_en = 1'b1;
    cyc(13);
    rot_en = 1'b0;
    cyc(2);
    chk_colors("rot_bwd", 24'hFFFFFF, 24'h0000FF, 24'h00FF00, 24'hFF0000);
    chk("rot_bwd_ledg", 32'(ledg), 32'd0);

    // press and counter wrap land on the same edge: write first, then rotate
    do_press(2'd0, 3'b000);
    SW2 = 2'd0; SW3 = 3'b111; rot_dir = 1'b0; rot_en = 1'b1;
    cyc(4);
    key3 = 1'b0;
    cyc(12);
    rot_en = 1'b0;
    key3   = 1'b1;
    cyc(12);
    chk_colors("collide", 24'h0000FF, 24'h00FF00, 24'hFF0000, 24'hFFFFFF);
    chk("collide_ledg", 32'(ledg), 32'd1);

    // reset asserted while a rotation is in flight
    rot_en = 1'b1;
    for (int i = 0; i < 40 && m_op != 2; i++) @(negedge clk);
    chk("rot_wait", 32'(m_op == 2), 32'd1);
    rst = 1'b0;
    cyc(2);
    chk_colors("rst_rot", 24'h0, 24'h0, 24'h0, 24'h0);
    chk("rst_rot_ledg", 32'(ledg), 32'd0);
    chk("rst_rot_state", 32'(state_dbg), 32'(IDLE));
    rot_en = 1'b0;
    rst    = 1'b1;

    // disabling rotation mid-count suppresses the rotation
    cyc(2);
    rot_en = 1'b1;
    cyc(6);
    rot_en = 1'b0;
    cyc(15);
    chk("noroll_ledg", 32'(ledg), 32'd0);
    chk("noroll_state", 32'(state_dbg), 32'(IDLE));

    // random traffic
    key_left = 0;
    for (int n = 0; n < 1500; n++) begin
      if (key_left == 0) begin
        key3     = ~key3;
        key_left = $urandom_range(1, 12);
      end
      key_left--;
      SW2     = 2'($urandom_range(0, 3));
      SW3     = 3'($urandom_range(0, 7));
      rot_dir = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 39) == 0) rot_en = ~rot_en;
      cyc(1);
    end
    key3   = 1'b1;
    rot_en = 1'b0;
    cyc(20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
